// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES GF(2^8) types, field constants and helper functions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0] column_t;

    localparam byte_t GF_POLY = 8'h1B;

    // Entry k is the coefficient applied to row (r + k) mod 4 when producing row r.
    localparam column_t MC_FWD = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam column_t MC_INV = {8'h09, 8'h0D, 8'h0B, 8'h0E};

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Constant multiply from precomputed powers: each set coefficient bit selects b*2^i.
    function automatic byte_t gf_mul_pre(
        input logic [3:0] coef,
        input byte_t      b,
        input byte_t      x2,
        input byte_t      x4,
        input byte_t      x8
    );
        byte_t acc;
        acc = 8'h00;
        if (coef[0]) acc = acc ^ b;
        if (coef[1]) acc = acc ^ x2;
        if (coef[2]) acc = acc ^ x4;
        if (coef[3]) acc = acc ^ x8;
        return acc;
    endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/mix_col_lane.sv
// ============================================================================
// Module  : mix_col_lane
// Brief   : Combinational stage-2 combine of one AES column (MixColumns, plus
//           InvMixColumns when MIXCOL_INV_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_col_lane
    import aes_pkg::*;
(
    input  column_t b_i,
    input  column_t x2_i,
`ifdef MIXCOL_INV_EN
    input  column_t x4_i,
    input  column_t x8_i,
    input  logic    inv_i,
`endif
    output column_t col_o
);

    column_t    w_col;
    logic [1:0] w_idx;

    always_comb begin
        w_col = '0;
        w_idx = 2'd0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                w_idx = 2'(r + k);
`ifdef MIXCOL_INV_EN
                w_col[2'(r)] = w_col[2'(r)] ^ gf_mul_pre(
                    inv_i ? MC_INV[2'(k)][3:0] : MC_FWD[2'(k)][3:0],
                    b_i[w_idx], x2_i[w_idx], x4_i[w_idx], x8_i[w_idx]);
`else
                w_col[2'(r)] = w_col[2'(r)] ^ gf_mul_pre(
                    MC_FWD[2'(k)][3:0], b_i[w_idx], x2_i[w_idx], 8'h00, 8'h00);
`endif
            end
        end
    end

    assign col_o = w_col;

endmodule : mix_col_lane

`default_nettype wire

// File: rtl/mix_columns_simd.sv
// ============================================================================
// Module  : mix_columns_simd
// Brief   : Two-stage pipelined AES MixColumns engine over LANES columns with a
//           valid/ready stream interface. MIXCOL_INV_EN adds InvMixColumns.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_columns_simd
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [32*LANES-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*LANES-1:0]  out_data,
    output logic                 busy
);

    localparam int NBYTES = 4 * LANES;
    localparam int DW     = 32 * LANES;

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_b_q,     s1_b_d;
    logic [DW-1:0] s1_x2_q,    s1_x2_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;

    logic [DW-1:0] w_x2;
    logic [DW-1:0] w_mix;
    logic          w_s2_ready;
    logic          w_s1_adv;
    logic          w_accept;

`ifdef MIXCOL_INV_EN
    logic [DW-1:0] s1_x4_q, s1_x4_d;
    logic [DW-1:0] s1_x8_q, s1_x8_d;
    logic          s1_inv_q, s1_inv_d;
    logic [DW-1:0] w_x4;
    logic [DW-1:0] w_x8;
`else
    logic          w_unused_inv;
    assign w_unused_inv = in_inv;
`endif

    // Stage-2 slot frees when empty or when its result leaves this cycle.
    assign w_s2_ready = !out_valid_q || out_ready;
    assign w_s1_adv   = s1_valid_q && w_s2_ready;
    assign in_ready   = !rst && (!s1_valid_q || w_s1_adv);
    assign w_accept   = in_valid && in_ready;

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        assign w_x2[8*i +: 8] = xtime(in_data[8*i +: 8]);
`ifdef MIXCOL_INV_EN
        assign w_x4[8*i +: 8] = xtime(w_x2[8*i +: 8]);
        assign w_x8[8*i +: 8] = xtime(w_x4[8*i +: 8]);
`endif
    end

    for (genvar c = 0; c < LANES; c++) begin : g_lane
        mix_col_lane u_lane (
            .b_i   (s1_b_q[32*c +: 32]),
            .x2_i  (s1_x2_q[32*c +: 32]),
`ifdef MIXCOL_INV_EN
            .x4_i  (s1_x4_q[32*c +: 32]),
            .x8_i  (s1_x8_q[32*c +: 32]),
            .inv_i (s1_inv_q),
`endif
            .col_o (w_mix[32*c +: 32])
        );
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_b_d      = s1_b_q;
        s1_x2_d     = s1_x2_q;
`ifdef MIXCOL_INV_EN
        s1_x4_d     = s1_x4_q;
        s1_x8_d     = s1_x8_q;
        s1_inv_d    = s1_inv_q;
`endif
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_b_d     = in_data;
            s1_x2_d    = w_x2;
`ifdef MIXCOL_INV_EN
            s1_x4_d    = w_x4;
            s1_x8_d    = w_x8;
            s1_inv_d   = in_inv;
`endif
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // out_data only moves with a new result, so it is stable under backpressure.
        if (w_s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = w_mix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_b_q      <= '0;
            s1_x2_q     <= '0;
`ifdef MIXCOL_INV_EN
            s1_x4_q     <= '0;
            s1_x8_q     <= '0;
            s1_inv_q    <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_b_q      <= s1_b_d;
            s1_x2_q     <= s1_x2_d;
`ifdef MIXCOL_INV_EN
            s1_x4_q     <= s1_x4_d;
            s1_x8_q     <= s1_x8_d;
            s1_inv_q    <= s1_inv_d;
`endif
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = s1_valid_q || out_valid_q;

endmodule : mix_columns_simd

`default_nettype wire
